instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Multi-cycle fetch sequencer placed directly downstream of the program counter. On a fetch request from the control unit it samples the current PC and issues a read to instruction memory using a req/ack handshake. It latches the returned word into the instruction register, then pulses a PC write-enable with PC+2 so the PC register advances. A flush input abandons an in-flight fetch for branch/jump redirects.

## Interface
- ADDR_W, 16, PC / memory address width
- DATA_W, 16, instruction word width
- PC_INC, 2, byte increment applied to the fetched PC
- TIMEOUT_CYCLES, 15, max wait for mem_ack (used only with the macro)

- CLK  in  1  rising-edge clock
- RST_N  in  1  reset, asynchronous, active-low
- fetch_start  in  1  control unit requests a fetch; sampled only in IDLE
- flush  in  1  abandon the current fetch
- pc_in  in  ADDR_W  current PC value from the PC register
- mem_req  out  1  read request to instruction memory
- mem_addr  out  ADDR_W  read address, stable while mem_req=1
- mem_ack  in  1  memory returns data this cycle
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1
- ir_out  out  DATA_W  instruction register
- fetch_done  out  1  one-cycle pulse: ir_out holds a new instruction
- pc_write  out  1  one-cycle write-enable to the PC register
- pc_next  out  ADDR_W  value to load into the PC
- busy  out  1  high in any state other than IDLE
- fetch_fault  out  1  sticky timeout flag

## Operation
- States:
  - IDLE, REQ, DRAIN, UPDATE.
- IDLE:
  - fetch_start=1 and flush=0 → latch addr_q=pc_in and pc_next=(pc_in+PC_INC) mod 2^ADDR_W, then go to REQ.
  - flush=1 has priority: stay in IDLE and ignore fetch_start.
- REQ:
  - Drives mem_req=1 and mem_addr=addr_q.
  - mem_ack=1, flush=0 → ir_out←mem_rdata, go to UPDATE.
  - mem_ack=1, flush=1 → discard data, go to IDLE.
  - flush=1 without ack → go to DRAIN.
- DRAIN:
  - Holds mem_req=1 until mem_ack arrives; a request is never retracted before ack.
  - On mem_ack, discard data and go to IDLE. ir_out, pc_write and fetch_done are untouched.
- UPDATE:
  - Asserts pc_write=1 and fetch_done=1 for exactly one cycle, then returns to IDLE.
  - flush in UPDATE is ignored; the update completes.
- fetch_start outside IDLE is ignored, with no queuing.
- Wrap-around: pc_in=0xFFFE gives pc_next=0x0000.
- Reset values: state IDLE; mem_req, fetch_done, pc_write, busy and fetch_fault are 0; mem_addr, ir_out and pc_next are 0.
- ir_out holds its value until the next successful fetch.

## Timing
- All outputs are registered or decoded from registered state only; no combinational path from input to output.
- Zero-wait memory: fetch_start at cycle 0, mem_req high in cycle 1, ack in cycle 1, fetch_done/pc_write in cycle 2, IDLE in cycle 3.
- With k wait cycles, fetch_done occurs at cycle 2+k.
- Minimum fetch-to-fetch spacing: 3 cycles.
- RST_N assertion mid-fetch clears everything immediately, and mem_req drops asynchronously. Memory must tolerate an abandoned request on reset.

## Configuration
- IFETCH_TIMEOUT_EN defined:
  - A counter runs while in REQ/DRAIN and clears on entry to REQ.
  - If TIMEOUT_CYCLES cycles elapse without mem_ack: set fetch_fault (sticky until RST_N), drop mem_req, go to IDLE, no pc_write.
  - Later fetches still operate normally.
- IFETCH_TIMEOUT_EN undefined:
  - Waits indefinitely.
  - fetch_fault is tied to 0 and no counter logic exists.

## Structure
- Package fetch_pkg holds:
  - fetch_state_t enum (IDLE, REQ, DRAIN, UPDATE);
  - PC_INC_DEFAULT;
  - the TIMEOUT_CYCLES default.
- One sub-module, fetch_timeout_counter. It has clear and enable inputs and an expired output, and is instantiated only under IFETCH_TIMEOUT_EN.

## Test plan
- Reset, then pc_in=0x0040, fetch_start pulse, memory acks in the first cycle with 0x1234:
  - ir_out=0x1234, pc_next=0x0042;
  - fetch_done and pc_write each one cycle at cycle 2.
- Ack delayed 4 cycles:
  - mem_addr stable at 0x0040 throughout;
  - fetch_done at cycle 6;
  - no repeat pulses.
- flush in the second REQ cycle, ack 2 cycles later:
  - mem_req is held until ack;
  - ir_out is unchanged and pc_write stays 0;
  - returns to IDLE.
- pc_in=0xFFFE:
  - pc_next=0x0000;
  - simultaneous flush+fetch_start in IDLE → no mem_req.
- RST_N low while in REQ:
  - mem_req=0 immediately, all outputs at reset values;
  - a new fetch after release completes normally.
- IFETCH_TIMEOUT_EN, no ack:
  - fetch_fault rises after 15 cycles in REQ and stays high;
  - a following fetch with ack still completes.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared state encoding and parameter defaults for the instruction fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      DRAIN  = 2'd2,
      UPDATE = 2'd3
   } fetch_state_t;

   localparam int unsigned PC_INC_DEFAULT         = 32'd2;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 32'd15;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory read channel: req/ack handshake with address and returned word.
interface instruction_fetch_if #(
   parameter int unsigned ADDR_W = 32'd16,
   parameter int unsigned DATA_W = 32'd16
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/fetch_timeout_counter.sv
// Wait-cycle counter for the fetch handshake; only instantiated when IFETCH_TIMEOUT_EN is defined.
module fetch_timeout_counter
   import fetch_pkg::*;
#(
   parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int unsigned      CNT_W = (LIMIT > 32'd1) ? $clog2(LIMIT) : 32'd1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(LIMIT - 32'd1);
   localparam logic [CNT_W-1:0] ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [CNT_W-1:0] cnt_r;

   // Count enabled cycles, saturating on the last one so expiry stays asserted.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_r <= ZERO;
      end else if (clear) begin
         cnt_r <= ZERO;
      end else if (enable && (cnt_r != LAST)) begin
         cnt_r <= cnt_r + ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expired = enable && (cnt_r == LAST);

endmodule

// File: rtl/instruction_fetch.sv
// Multi-cycle fetch sequencer between the PC register and instruction memory.
// Define IFETCH_TIMEOUT_EN to abandon unanswered requests and raise a sticky fetch_fault.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32'd16,
   parameter int unsigned DATA_W         = 32'd16,
   parameter int unsigned PC_INC         = PC_INC_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                fetch_start,
   input  logic                flush,
   input  logic [ADDR_W-1:0]   pc_in,
   instruction_fetch_if.master mem,
   output logic [DATA_W-1:0]   ir_out,
   output logic                fetch_done,
   output logic                pc_write,
   output logic [ADDR_W-1:0]   pc_next,
   output logic                busy,
   output logic                fetch_fault
);
   localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(PC_INC);
   localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
   localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);

   fetch_state_t      state_r;
   fetch_state_t      state_next_s;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] pc_next_r;
   logic [DATA_W-1:0] ir_r;
   logic              start_s;
   logic              waiting_s;
   logic              timeout_s;

   assign start_s   = (state_r == IDLE) && fetch_start && !flush;
   assign waiting_s = (state_r == REQ) || (state_r == DRAIN);

`ifdef IFETCH_TIMEOUT_EN
   logic expired_s;
   logic fault_r;

   fetch_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .clear   (state_r == IDLE),
      .enable  (waiting_s),
      .expired (expired_s)
   );

   // A late ack in the expiry cycle still wins over the timeout.
   assign timeout_s = expired_s && !mem.mem_ack;

   // Sticky fault flag, cleared only by reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fault_r <= 1'b0;
      end else if (timeout_s) begin
         fault_r <= 1'b1;
      end else begin
         fault_r <= fault_r;
      end
   end

   assign fetch_fault = fault_r;
`else
   logic unused_cfg_s;
   assign unused_cfg_s = (TIMEOUT_CYCLES != 32'd0);
   assign timeout_s    = 1'b0;
   assign fetch_fault  = 1'b0;
`endif

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; a pending request is only left on ack or timeout.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_s) state_next_s = REQ;
            else         state_next_s = IDLE;
         end
         REQ: begin
            if (mem.mem_ack)    state_next_s = flush ? IDLE : UPDATE;
            else if (timeout_s) state_next_s = IDLE;
            else if (flush)     state_next_s = DRAIN;
            else                state_next_s = REQ;
         end
         DRAIN: begin
            if (mem.mem_ack || timeout_s) state_next_s = IDLE;
            else                          state_next_s = DRAIN;
         end
         UPDATE:  state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Control outputs decoded from the registered state only.
   always_comb begin
      mem.mem_req = 1'b0;
      busy        = 1'b1;
      fetch_done  = 1'b0;
      pc_write    = 1'b0;
      case (state_r)
         IDLE:  busy = 1'b0;
         REQ:   mem.mem_req = 1'b1;
         DRAIN: mem.mem_req = 1'b1;
         UPDATE: begin
            fetch_done = 1'b1;
            pc_write   = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

   // Capture the fetch address and its successor when a fetch is accepted.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         addr_r    <= ADDR_ZERO;
         pc_next_r <= ADDR_ZERO;
      end else if (start_s) begin
         addr_r    <= pc_in;
         pc_next_r <= pc_in + PC_STEP;
      end else begin
         addr_r    <= addr_r;
         pc_next_r <= pc_next_r;
      end
   end

   // Instruction register loads only on an unflushed ack.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ir_r <= DATA_ZERO;
      end else if ((state_r == REQ) && mem.mem_ack && !flush) begin
         ir_r <= mem.mem_rdata;
      end else begin
         ir_r <= ir_r;
      end
   end

   assign mem.mem_addr = addr_r;
   assign ir_out       = ir_r;
   assign pc_next      = pc_next_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected words/PCs queued at stimulus, checked on fetch_done.
module tb_instruction_fetch;

   logic        CLK;
   logic        RST_N;
   logic        fetch_start;
   logic        flush;
   logic [15:0] pc_in;
   logic [15:0] ir_out;
   logic        fetch_done;
   logic        pc_write;
   logic [15:0] pc_next;
   logic        busy;
   logic        fetch_fault;

   instruction_fetch_if #(.ADDR_W(16), .DATA_W(16)) mem_if ();

   instruction_fetch #(
      .ADDR_W(16), .DATA_W(16), .PC_INC(2), .TIMEOUT_CYCLES(15)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .fetch_start (fetch_start),
      .flush       (flush),
      .pc_in       (pc_in),
      .mem         (mem_if),
      .ir_out      (ir_out),
      .fetch_done  (fetch_done),
      .pc_write    (pc_write),
      .pc_next     (pc_next),
      .busy        (busy),
      .fetch_fault (fetch_fault)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [15:0] exp_ir_q[$];
   logic [15:0] exp_pc_q[$];

   int          obs_done_cyc, obs_pcw_cyc, obs_n_done, obs_n_pcw, obs_fault_cyc;
   logic        obs_addr_ok, obs_req_held;
   logic [15:0] obs_ir, obs_pcn;

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Starts one fetch at cycle 0; ack at cycle ack_c (-1: never), flush pulse at flush_c.
   task automatic run_fetch(input logic [15:0] pc, input logic [15:0] data,
                            input int ack_c, input int flush_c, input int ncyc);
      fetch_start     = 1'b1;
      flush           = 1'b0;
      pc_in           = pc;
      mem_if.mem_ack  = 1'b0;
      obs_done_cyc    = -1;
      obs_pcw_cyc     = -1;
      obs_fault_cyc   = -1;
      obs_n_done      = 0;
      obs_n_pcw       = 0;
      obs_addr_ok     = 1'b1;
      obs_req_held    = 1'b1;
      obs_ir          = 16'h0000;
      obs_pcn         = 16'h0000;
      tick();
      fetch_start = 1'b0;
      pc_in       = ~pc;
      for (int c = 1; c < ncyc; c++) begin
         if (fetch_done === 1'b1) begin
            obs_n_done++;
            if (obs_done_cyc < 0) begin
               obs_done_cyc = c;
               obs_ir       = ir_out;
               obs_pcn      = pc_next;
            end
         end
         if (pc_write === 1'b1) begin
            obs_n_pcw++;
            if (obs_pcw_cyc < 0) obs_pcw_cyc = c;
         end
         if ((fetch_fault === 1'b1) && (obs_fault_cyc < 0)) obs_fault_cyc = c;
         if (c <= ack_c) begin
            if (mem_if.mem_req !== 1'b1) obs_req_held = 1'b0;
            if (mem_if.mem_addr !== pc)  obs_addr_ok  = 1'b0;
         end
         flush            = (c == flush_c);
         mem_if.mem_ack   = (c == ack_c);
         mem_if.mem_rdata = (c == ack_c) ? data : 16'hDEAD;
         tick();
      end
      flush          = 1'b0;
      mem_if.mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      tick();
      tick();
      total_cnt++;
      if ({mem_if.mem_req, busy, fetch_done, pc_write, fetch_fault} !== 5'b00000)
         $display("FAIL reset_ctrl: got %b expected 00000",
                  {mem_if.mem_req, busy, fetch_done, pc_write, fetch_fault});
      else pass_cnt++;
      total_cnt++;
      if ({mem_if.mem_addr, ir_out, pc_next} !== 48'h0)
         $display("FAIL reset_data: got %h expected 0", {mem_if.mem_addr, ir_out, pc_next});
      else pass_cnt++;
      RST_N = 1'b1;
      tick();
   endtask

   task automatic test_zero_wait();
      logic [15:0] e_ir, e_pc;
      exp_ir_q.push_back(16'h1234);
      exp_pc_q.push_back(16'h0042);
      run_fetch(16'h0040, 16'h1234, 1, -1, 5);
      total_cnt++;
      if (obs_done_cyc != 2) $display("FAIL zw_done_cyc: got %0d expected 2", obs_done_cyc);
      else pass_cnt++;
      total_cnt++;
      if ((obs_pcw_cyc != 2) || (obs_n_pcw != 1) || (obs_n_done != 1))
         $display("FAIL zw_pulses: got pcw_cyc=%0d n_pcw=%0d n_done=%0d expected 2/1/1",
                  obs_pcw_cyc, obs_n_pcw, obs_n_done);
      else pass_cnt++;
      if ((obs_n_done > 0) && (exp_ir_q.size() > 0)) begin
         e_ir = exp_ir_q.pop_front();
         e_pc = exp_pc_q.pop_front();
         total_cnt++;
         if (obs_ir !== e_ir) $display("FAIL zw_ir: got %h expected %h", obs_ir, e_ir);
         else pass_cnt++;
         total_cnt++;
         if (obs_pcn !== e_pc) $display("FAIL zw_pc_next: got %h expected %h", obs_pcn, e_pc);
         else pass_cnt++;
      end
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL zw_idle: got busy=%b expected 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_wait_states();
      logic [15:0] e_ir, e_pc;
      exp_ir_q.push_back(16'hABCD);
      exp_pc_q.push_back(16'h0042);
      run_fetch(16'h0040, 16'hABCD, 5, -1, 9);
      total_cnt++;
      if (obs_done_cyc != 6) $display("FAIL ws_done_cyc: got %0d expected 6", obs_done_cyc);
      else pass_cnt++;
      total_cnt++;
      if ((obs_addr_ok !== 1'b1) || (obs_req_held !== 1'b1))
         $display("FAIL ws_addr_stable: got addr_ok=%b req_held=%b expected 1/1",
                  obs_addr_ok, obs_req_held);
      else pass_cnt++;
      total_cnt++;
      if ((obs_n_done != 1) || (obs_n_pcw != 1))
         $display("FAIL ws_repeat: got n_done=%0d n_pcw=%0d expected 1/1", obs_n_done, obs_n_pcw);
      else pass_cnt++;
      if ((obs_n_done > 0) && (exp_ir_q.size() > 0)) begin
         e_ir = exp_ir_q.pop_front();
         e_pc = exp_pc_q.pop_front();
         total_cnt++;
         if ({obs_ir, obs_pcn} !== {e_ir, e_pc})
            $display("FAIL ws_data: got %h/%h expected %h/%h", obs_ir, obs_pcn, e_ir, e_pc);
         else pass_cnt++;
      end
   endtask

   task automatic test_flush_drain();
      run_fetch(16'h0100, 16'h5555, 4, 2, 7);
      total_cnt++;
      if (obs_req_held !== 1'b1) $display("FAIL fl_req_held: got %b expected 1", obs_req_held);
      else pass_cnt++;
      total_cnt++;
      if ((obs_n_pcw != 0) || (obs_n_done != 0))
         $display("FAIL fl_no_update: got n_pcw=%0d n_done=%0d expected 0/0", obs_n_pcw, obs_n_done);
      else pass_cnt++;
      total_cnt++;
      if (ir_out !== 16'hABCD) $display("FAIL fl_ir_kept: got %h expected abcd", ir_out);
      else pass_cnt++;
      total_cnt++;
      if ({busy, mem_if.mem_req} !== 2'b00)
         $display("FAIL fl_idle: got busy/req=%b expected 00", {busy, mem_if.mem_req});
      else pass_cnt++;
      // flush coinciding with the ack also discards the word
      run_fetch(16'h0110, 16'h6666, 1, 1, 4);
      total_cnt++;
      if ((obs_n_done != 0) || (ir_out !== 16'hABCD) || (busy !== 1'b0))
         $display("FAIL fl_ack_same: got n_done=%0d ir=%h busy=%b expected 0/abcd/0",
                  obs_n_done, ir_out, busy);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      logic [15:0] e_ir, e_pc, pc_v;
      logic        saw_req;
      pc_v = 16'hFFFE;
      exp_ir_q.push_back(16'h0F0F);
      exp_pc_q.push_back(pc_v + 16'd2);
      run_fetch(pc_v, 16'h0F0F, 2, -1, 6);
      total_cnt++;
      if (obs_done_cyc != 3) $display("FAIL wr_done_cyc: got %0d expected 3", obs_done_cyc);
      else pass_cnt++;
      if ((obs_n_done > 0) && (exp_ir_q.size() > 0)) begin
         e_ir = exp_ir_q.pop_front();
         e_pc = exp_pc_q.pop_front();
         total_cnt++;
         if ({obs_ir, obs_pcn} !== {e_ir, e_pc})
            $display("FAIL wr_pc_next: got %h/%h expected %h/%h", obs_ir, obs_pcn, e_ir, e_pc);
         else pass_cnt++;
      end
      fetch_start = 1'b1;
      flush       = 1'b1;
      pc_in       = 16'h0500;
      saw_req     = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if ((mem_if.mem_req !== 1'b0) || (busy !== 1'b0)) saw_req = 1'b1;
      end
      fetch_start = 1'b0;
      flush       = 1'b0;
      total_cnt++;
      if (saw_req !== 1'b0) $display("FAIL wr_flush_prio: got req/busy seen=%b expected 0", saw_req);
      else pass_cnt++;
      total_cnt++;
      if (pc_next !== 16'h0000) $display("FAIL wr_no_latch: got %h expected 0000", pc_next);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int          dcyc[$];
      int          exp_d[3] = '{2, 5, 8};
      int          got;
      logic [15:0] e_ir, e_pc, d;
      fetch_start = 1'b1;
      pc_in       = 16'h0200;
      tick();
      for (int c = 1; c <= 10; c++) begin
         if (fetch_done === 1'b1) begin
            dcyc.push_back(c);
            if (exp_ir_q.size() > 0) begin
               e_ir = exp_ir_q.pop_front();
               e_pc = exp_pc_q.pop_front();
               total_cnt++;
               if ({ir_out, pc_next} !== {e_ir, e_pc})
                  $display("FAIL b2b_data: got %h/%h expected %h/%h", ir_out, pc_next, e_ir, e_pc);
               else pass_cnt++;
            end
         end
         fetch_start      = (c < 9);
         d                = 16'h1000 + c[15:0];
         mem_if.mem_ack   = mem_if.mem_req;
         mem_if.mem_rdata = d;
         if (mem_if.mem_req === 1'b1) begin
            exp_ir_q.push_back(d);
            exp_pc_q.push_back(16'h0202);
         end
         tick();
      end
      fetch_start    = 1'b0;
      mem_if.mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         got = (i < dcyc.size()) ? dcyc[i] : -1;
         total_cnt++;
         if (got != exp_d[i]) $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, got, exp_d[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (dcyc.size() != 3) $display("FAIL b2b_count: got %0d expected 3", dcyc.size());
      else pass_cnt++;
   endtask

   task automatic test_reset_midfetch();
      logic [15:0] e_ir, e_pc;
      fetch_start    = 1'b1;
      pc_in          = 16'h0300;
      mem_if.mem_ack = 1'b0;
      tick();
      fetch_start = 1'b0;
      total_cnt++;
      if (mem_if.mem_req !== 1'b1) $display("FAIL rm_in_req: got %b expected 1", mem_if.mem_req);
      else pass_cnt++;
      tick();
      #2 RST_N = 1'b0;
      #1;
      total_cnt++;
      if ({mem_if.mem_req, busy, fetch_done, pc_write} !== 4'b0000)
         $display("FAIL rm_async_ctrl: got %b expected 0000",
                  {mem_if.mem_req, busy, fetch_done, pc_write});
      else pass_cnt++;
      total_cnt++;
      if ({mem_if.mem_addr, ir_out, pc_next} !== 48'h0)
         $display("FAIL rm_async_data: got %h expected 0", {mem_if.mem_addr, ir_out, pc_next});
      else pass_cnt++;
      @(negedge CLK);
      RST_N = 1'b1;
      exp_ir_q.push_back(16'h7777);
      exp_pc_q.push_back(16'h0312);
      run_fetch(16'h0310, 16'h7777, 3, -1, 7);
      total_cnt++;
      if (obs_done_cyc != 4) $display("FAIL rm_after_done: got %0d expected 4", obs_done_cyc);
      else pass_cnt++;
      if ((obs_n_done > 0) && (exp_ir_q.size() > 0)) begin
         e_ir = exp_ir_q.pop_front();
         e_pc = exp_pc_q.pop_front();
         total_cnt++;
         if ({obs_ir, obs_pcn} !== {e_ir, e_pc})
            $display("FAIL rm_after_data: got %h/%h expected %h/%h", obs_ir, obs_pcn, e_ir, e_pc);
         else pass_cnt++;
      end
   endtask

   task automatic test_timeout();
      logic [15:0] e_ir, e_pc;
`ifdef IFETCH_TIMEOUT_EN
      run_fetch(16'h0600, 16'h9999, -1, -1, 20);
      total_cnt++;
      if (obs_fault_cyc != 16) $display("FAIL to_fault_cyc: got %0d expected 16", obs_fault_cyc);
      else pass_cnt++;
      total_cnt++;
      if ((obs_n_pcw != 0) || (busy !== 1'b0) || (mem_if.mem_req !== 1'b0))
         $display("FAIL to_abandon: got n_pcw=%0d busy=%b req=%b expected 0/0/0",
                  obs_n_pcw, busy, mem_if.mem_req);
      else pass_cnt++;
      exp_ir_q.push_back(16'h4242);
      exp_pc_q.push_back(16'h0702);
      run_fetch(16'h0700, 16'h4242, 1, -1, 5);
      total_cnt++;
      if ((obs_done_cyc != 2) || (fetch_fault !== 1'b1))
         $display("FAIL to_recover: got done_cyc=%0d fault=%b expected 2/1", obs_done_cyc, fetch_fault);
      else pass_cnt++;
`else
      exp_ir_q.push_back(16'h4242);
      exp_pc_q.push_back(16'h0702);
      run_fetch(16'h0700, 16'h4242, 26, -1, 30);
      total_cnt++;
      if ((obs_done_cyc != 27) || (obs_fault_cyc != -1))
         $display("FAIL to_long_wait: got done_cyc=%0d fault_cyc=%0d expected 27/-1",
                  obs_done_cyc, obs_fault_cyc);
      else pass_cnt++;
`endif
      if ((obs_n_done > 0) && (exp_ir_q.size() > 0)) begin
         e_ir = exp_ir_q.pop_front();
         e_pc = exp_pc_q.pop_front();
         total_cnt++;
         if ({obs_ir, obs_pcn} !== {e_ir, e_pc})
            $display("FAIL to_data: got %h/%h expected %h/%h", obs_ir, obs_pcn, e_ir, e_pc);
         else pass_cnt++;
      end
   endtask

   initial begin
      RST_N            = 1'b0;
      fetch_start      = 1'b0;
      flush            = 1'b0;
      pc_in            = 16'h0000;
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = 16'h0000;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_flush_drain();
      test_wrap();
      test_back_to_back();
      test_reset_midfetch();
      test_timeout();
      total_cnt++;
      if (exp_ir_q.size() != 0) $display("FAIL sb_leftover: got %0d expected 0", exp_ir_q.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
